// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
// Read-side controller for the circular FIFO core. It pops words from the
// FIFO's registered read port, which returns data one cycle after rd_en. It
// stages the returned words in a 2-entry skid buffer and presents them on a
// valid/ready stream. The stream can sustain one word per cycle. A flush drains
// the FIFO and discards every word it returns.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no new reads issued; buffered words still offered downstream
// S_RUN   | reads issued while skid + in-flight capacity allows
// S_FLUSH | skid empty, FIFO drained, returned data dropped, m_valid low

module fifo_read_ctrl #(
   parameter int WIDTH         = 8,
   parameter int POINTER_WIDTH = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   flush,
   input  logic [POINTER_WIDTH:0] fifo_count,
   input  logic [WIDTH-1:0]       fifo_rd_data,
   output logic                   fifo_rd_en,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH-1:0]       m_data,
   output logic                   flush_done,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   words_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] skid0;
   logic [WIDTH-1:0] skid1;
   logic             rd_ptr;
   logic [1:0]       occ;
   logic             inflight;

   logic             fifo_avail;
   logic             handshake;
   logic [1:0]       pending;
   logic             flush_entry;
   logic             flush_exit;
   logic             wr_sel;
   logic [1:0]       occ_nxt;

   // Availability comes only from the FIFO's registered occupancy. That value
   // updates on the same edge that pops a word, so back-to-back reads cannot
   // pop more words than the FIFO holds.
   assign fifo_avail = (fifo_count != '0);
   assign pending    = occ + {1'b0, inflight};
   assign m_valid    = (occ != 2'd0) && (state != S_FLUSH);
   assign m_data     = rd_ptr ? skid1 : skid0;
   assign handshake  = m_valid && m_ready;
   assign busy       = (state != S_IDLE) || (occ != 2'd0) || inflight;

   assign flush_entry = (state != S_FLUSH) && (state_nxt == S_FLUSH);
   assign flush_exit  = (state == S_FLUSH) && (state_nxt == S_IDLE);

   // A word arriving from the FIFO goes into the slot just behind the head.
   // A push while occ==2 cannot happen, because pending never exceeds 2.
   assign wr_sel  = rd_ptr ^ occ[0];
   assign occ_nxt = occ + {1'b0, inflight} - {1'b0, handshake};

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and FIFO pop request
   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         S_IDLE: begin
            if (flush) begin
               state_nxt = S_FLUSH;
            end else if (enable) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // A pop is allowed when a slot is free. When the skid is full, a
            // pop is also allowed if a word leaves on this same cycle.
            fifo_rd_en = fifo_avail &&
                         ((pending < 2'd2) ||
                          ((pending == 2'd2) && handshake));
            if (flush) begin
               state_nxt = S_FLUSH;
            end else if (!enable) begin
               state_nxt = S_IDLE;
            end
         end
         S_FLUSH: begin
            fifo_rd_en = fifo_avail;
            if (!fifo_avail && !inflight && !flush) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Read-in-flight tracker: the FIFO returns data one cycle after the pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
      end
   end

   // Skid buffer occupancy and head pointer. Flush entry and the whole FLUSH
   // state keep the buffer empty. Any handshake on the entry cycle has already
   // completed downstream before the buffer clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ    <= 2'd0;
         rd_ptr <= 1'b0;
      end else if (flush_entry || (state == S_FLUSH)) begin
         occ    <= 2'd0;
         rd_ptr <= 1'b0;
      end else begin
         occ <= occ_nxt;
         if (handshake) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Skid buffer data capture; returned words are dropped while flushing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid0 <= '0;
         skid1 <= '0;
      end else if (inflight && !flush_entry && (state != S_FLUSH)) begin
         if (wr_sel) begin
            skid1 <= fifo_rd_data;
         end else begin
            skid0 <= fifo_rd_data;
         end
      end
   end

   // One-cycle flush_done pulse on the cycle after FLUSH exits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_done <= 1'b0;
      end else begin
         flush_done <= flush_exit;
      end
   end

   // Delivered-word counter; wraps naturally and survives flushes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         words_out <= '0;
      end else if (handshake) begin
         words_out <= words_out + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl. It models the FIFO core as a queue,
// and a scoreboard holds the words that were popped but not yet delivered.
// A second instance with a 4-bit counter shares the same stimulus.

module tb_fifo_read_ctrl;

   localparam int WIDTH = 8;
   localparam int PW    = 4;
   localparam int DEPTH = 16;

   logic             clk;
   logic             reset_n;
   logic             enable;
   logic             flush;
   logic [PW:0]      fifo_count;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             m_ready;

   logic             fifo_rd_en;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             flush_done;
   logic             busy;
   logic [15:0]      words_out;

   logic             fifo_rd_en4;
   logic             m_valid4;
   logic [WIDTH-1:0] m_data4;
   logic             flush_done4;
   logic             busy4;
   logic [3:0]       words_out4;

   fifo_read_ctrl #(.WIDTH(WIDTH), .POINTER_WIDTH(PW), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .fifo_count(fifo_count), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .flush_done(flush_done), .busy(busy),
      .words_out(words_out)
   );

   fifo_read_ctrl #(.WIDTH(WIDTH), .POINTER_WIDTH(PW), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .fifo_count(fifo_count), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4), .m_ready(m_ready),
      .m_data(m_data4), .flush_done(flush_done4), .busy(busy4),
      .words_out(words_out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] next_word;
   bit               pend_v;
   bit               fmode;
   bit               exp_fd;
   bit               may_run;
   bit               push_req;
   int               wcnt;
   int               cyc;
   int               first_hs;
   int               last_hs;
   int               fd_seen;

   int               n_checks;
   int               n_fail;

   task automatic chk_eq(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         if (fifo_q.size() < DEPTH) begin
            fifo_q.push_back(next_word);
            next_word = next_word + 8'd1;
         end
      end
      fifo_count = (PW+1)'(fifo_q.size());
   endtask

   // One clock cycle: check at the falling edge, then advance the model just
   // after the rising edge, which is also where inputs change.
   task automatic tick();
      bit hs, rd, en_s, fl_s, fm_before, pv_before, entering;
      int cnt_before;
      @(negedge clk);
      chk_eq("m_valid", m_valid, (sb.size() != 0) && !fmode);
      chk_eq("m_valid4", m_valid4, (sb.size() != 0) && !fmode);
      if (m_valid && sb.size() != 0) chk_eq("m_data", m_data, sb[0]);
      if (m_valid4 && sb.size() != 0) chk_eq("m_data4", m_data4, sb[0]);
      if (!fmode) chk_eq("occ_bound", (sb.size() + pend_v) <= 2, 1);
      if (!fmode && !may_run) begin
         chk_eq("rd_en_idle", fifo_rd_en, 0);
         chk_eq("rd_en_idle4", fifo_rd_en4, 0);
      end
      if (fifo_rd_en) chk_eq("over_pop", fifo_q.size() != 0, 1);
      chk_eq("flush_done", flush_done, exp_fd);
      chk_eq("flush_done4", flush_done4, exp_fd);
      if (flush_done) begin
         fd_seen++;
         chk_eq("busy_at_fd", busy, 0);
      end
      chk_eq("words_out", words_out, wcnt[15:0]);
      chk_eq("words_out4", words_out4, wcnt[3:0]);
      hs   = m_valid && m_ready;
      rd   = fifo_rd_en;
      en_s = enable;
      fl_s = flush;
      @(posedge clk);
      #1;
      fm_before  = fmode;
      pv_before  = pend_v;
      cnt_before = fifo_q.size();
      if (hs) begin
         if (sb.size() != 0) void'(sb.pop_front());
         wcnt++;
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
      end
      entering = !fmode && fl_s;
      if (pend_v && !fmode && !entering) sb.push_back(pend);
      if (entering) begin
         sb.delete();
         fmode = 1;
      end
      pend_v = rd;
      if (rd && fifo_q.size() != 0) pend = fifo_q.pop_front();
      exp_fd = 0;
      if (fm_before && cnt_before == 0 && !pv_before && !fl_s) begin
         fmode  = 0;
         exp_fd = 1;
      end
      may_run = en_s && !fl_s && !fm_before;
      if (push_req && fifo_q.size() < DEPTH) begin
         fifo_q.push_back(next_word);
         next_word = next_word + 8'd1;
      end
      fifo_count   = (PW+1)'(fifo_q.size());
      fifo_rd_data = pend;
      cyc++;
   endtask

   task automatic drain(input string tag, input int limit);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || sb.size() != 0 || pend_v) && n < limit) begin
         tick();
         n++;
      end
      if (n >= limit) chk_eq(tag, 0, 1);
   endtask

   int base;
   int hold_cnt;
   int lim;

   initial begin
      n_checks = 0; n_fail = 0;
      reset_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
      fifo_count = '0; fifo_rd_data = '0; push_req = 0;
      pend = '0; pend_v = 0; fmode = 0; exp_fd = 0; may_run = 0;
      wcnt = 0; cyc = 0; first_hs = -1; last_hs = -1; fd_seen = 0;
      next_word = 8'd1;

      #12;
      chk_eq("rst_m_valid", m_valid, 0);
      chk_eq("rst_m_data", m_data, 0);
      chk_eq("rst_rd_en", fifo_rd_en, 0);
      chk_eq("rst_flush_done", flush_done, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_words_out", words_out, 0);

      // streaming burst of 01..05
      push_words(5);
      @(posedge clk); #1;
      reset_n = 1'b1;
      enable  = 1'b1;
      m_ready = 1'b1;
      repeat (12) tick();
      chk_eq("burst_words", words_out, 5);
      chk_eq("burst_span", last_hs - first_hs, 4);

      // backpressure: only two words popped ahead
      m_ready = 1'b0;
      push_words(8);
      repeat (10) tick();
      chk_eq("bp_fifo_count", fifo_count, 6);
      chk_eq("bp_m_valid", m_valid, 1);
      chk_eq("bp_head", m_data, 6);
      m_ready = 1'b1;
      drain("bp_drain_timeout", 40);
      chk_eq("bp_words", words_out, 13);

      // toggling ready over 16 words
      push_words(16);
      lim = 0;
      while ((fifo_q.size() != 0 || sb.size() != 0 || pend_v) && lim < 80) begin
         m_ready = (lim % 2 == 0);
         tick();
         lim++;
      end
      if (lim >= 80) chk_eq("tog_timeout", 0, 1);
      chk_eq("tog_words", words_out, 29);

      // one-cycle flush mid-stream
      m_ready = 1'b1;
      push_words(6);
      repeat (2) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      fd_seen = 0;
      lim = 0;
      while (fd_seen == 0 && lim < 40) begin
         m_ready = ($urandom_range(0, 1) == 1);
         tick();
         lim++;
      end
      if (lim >= 40) chk_eq("flush_timeout", 0, 1);
      repeat (3) tick();
      chk_eq("flush_pulses", fd_seen, 1);
      chk_eq("flush_fifo_empty", fifo_count, 0);

      // enable drops while a read is in flight
      m_ready = 1'b0;
      push_words(4);
      lim = 0;
      while (!pend_v && lim < 10) begin
         tick();
         lim++;
      end
      if (lim >= 10) chk_eq("en_rd_timeout", 0, 1);
      enable = 1'b0;
      repeat (6) tick();
      hold_cnt = fifo_q.size();
      m_ready = 1'b1;
      repeat (4) tick();
      chk_eq("en_hold_count", fifo_count, hold_cnt);
      chk_eq("en_delivered", sb.size() + pend_v, 0);
      chk_eq("en_idle_valid", m_valid, 0);
      enable = 1'b1;
      drain("en_drain_timeout", 40);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         enable   = ($urandom_range(0, 7) != 0);
         m_ready  = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 63) == 0);
         push_req = ($urandom_range(0, 1) == 1);
         tick();
      end
      flush = 1'b0; enable = 1'b1; m_ready = 1'b1; push_req = 0;
      repeat (3) tick();
      drain("rand_drain_timeout", 200);

      // reset mid-burst
      push_words(10);
      repeat (4) tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk_eq("mid_rst_m_valid", m_valid, 0);
      chk_eq("mid_rst_rd_en", fifo_rd_en, 0);
      chk_eq("mid_rst_words", words_out, 0);
      chk_eq("mid_rst_words4", words_out4, 0);
      chk_eq("mid_rst_busy", busy, 0);
      sb.delete(); pend_v = 0; fmode = 0; wcnt = 0; exp_fd = 0; may_run = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      drain("rst_drain_timeout", 60);

      // 17 more words through the 4-bit counter
      base = wcnt;
      push_words(16);
      drain("wrap_drain_a", 60);
      push_words(1);
      drain("wrap_drain_b", 20);
      chk_eq("wrap4_words", words_out4, 4'(base + 17));
      chk_eq("wrap16_words", words_out, 16'(base + 17));

      enable = 1'b0;
      repeat (3) tick();
      chk_eq("end_busy", busy, 0);
      chk_eq("end_busy4", busy4, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
